// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the execute stage and the iterative multiply/divide unit.
// The execute stage is the master; muldiv_unit is the slave.
interface muldiv_unit_if #(
  parameter int XLEN = 32
);
  logic            En;
  logic            Start;
  logic [2:0]      Op;
  logic [XLEN-1:0] DataA;
  logic [XLEN-1:0] DataB;
  logic            Busy;
  logic            Done;
  logic [XLEN-1:0] Result;

  modport master (
    output En, Start, Op, DataA, DataB,
    input  Busy, Done, Result
  );

  modport slave (
    input  En, Start, Op, DataA, DataB,
    output Busy, Done, Result
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: radix-2 shift/add multiply and restoring divide on
// operand magnitudes, with the sign applied once at the end. Fixed latency for every op.
module muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic         Clk,
  input  logic         Rst_n,
  muldiv_unit_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIXUP,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic [XLEN-1:0]   a_mag_q, a_mag_d;
  logic [XLEN-1:0]   b_mag_q, b_mag_d;
  logic [XLEN-1:0]   hi_q, hi_d;
  logic [XLEN-1:0]   lo_q, lo_d;
  logic              neg_q, neg_d;
  logic              rem_neg_q, rem_neg_d;
  logic [XLEN-1:0]   result_q, result_d;

  // Operand conditioning at acceptance
  logic              signed_a, signed_b;
  logic              a_neg, b_neg;
  logic [XLEN-1:0]   a_abs, b_abs;

  always_comb begin
    signed_a = (bus.Op == 3'd1) || (bus.Op == 3'd2) || (bus.Op == 3'd4) || (bus.Op == 3'd6);
    signed_b = (bus.Op == 3'd1) || (bus.Op == 3'd4) || (bus.Op == 3'd6);
    a_neg    = signed_a && bus.DataA[XLEN-1];
    b_neg    = signed_b && bus.DataB[XLEN-1];
    // 0x80000000 negates to itself, which read unsigned is exactly 2^31.
    a_abs    = a_neg ? ({XLEN{1'b0}} - bus.DataA) : bus.DataA;
    b_abs    = b_neg ? ({XLEN{1'b0}} - bus.DataB) : bus.DataB;
  end

  // One multiply step: conditional add into the high half, then shift the pair right
  logic [XLEN:0]     mul_sum;
  logic [XLEN-1:0]   mul_hi, mul_lo;

  always_comb begin
    mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_mag_q} : {(XLEN+1){1'b0}});
    mul_hi  = mul_sum[XLEN:1];
    mul_lo  = {mul_sum[0], lo_q[XLEN-1:1]};
  end

  // One restoring divide step; hi holds the remainder, lo shifts dividend out and quotient in
  logic [XLEN:0]     div_shift;
  logic              div_ge;
  logic [XLEN-1:0]   div_hi, div_lo;

  always_comb begin
    div_shift = {hi_q, lo_q[XLEN-1]};
    div_ge    = (div_shift >= {1'b0, b_mag_q});
    div_hi    = div_ge ? (div_shift[XLEN-1:0] - b_mag_q) : div_shift[XLEN-1:0];
    div_lo    = {lo_q[XLEN-2:0], div_ge};
  end

  // Sign fixup and result selection
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quo_s, rem_s, fix_result;

  always_comb begin
    prod_s = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
    quo_s  = neg_q ? -lo_q : lo_q;
    rem_s  = rem_neg_q ? -hi_q : hi_q;
    case (op_q)
      3'd0:                fix_result = prod_s[XLEN-1:0];
      3'd1, 3'd2, 3'd3:    fix_result = prod_s[2*XLEN-1:XLEN];
      3'd4, 3'd5:          fix_result = quo_s;
      default:             fix_result = rem_s;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    a_mag_d   = a_mag_q;
    b_mag_d   = b_mag_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    result_d  = result_q;
    if (bus.En) begin
      case (state_q)
        S_IDLE: begin
          if (bus.Start) begin
            state_d   = S_CALC;
            cnt_d     = '0;
            op_d      = bus.Op;
            a_mag_d   = a_abs;
            b_mag_d   = b_abs;
            // A zero divisor yields an all-ones quotient regardless of signs.
            neg_d     = bus.Op[2] ? ((a_neg ^ b_neg) && (bus.DataB != '0)) : (a_neg ^ b_neg);
            rem_neg_d = a_neg;
            hi_d      = '0;
            lo_d      = bus.Op[2] ? a_abs : b_abs;
          end
        end
        S_CALC: begin
          cnt_d = cnt_q + 1'b1;
          if (op_q[2]) begin
            hi_d = div_hi;
            lo_d = div_lo;
          end else begin
            hi_d = mul_hi;
            lo_d = mul_lo;
          end
          if (cnt_q == CNT_W'(XLEN-1)) begin
            state_d = S_FIXUP;
          end
        end
        S_FIXUP: begin
          result_d = fix_result;
          state_d  = S_DONE;
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      a_mag_q   <= '0;
      b_mag_q   <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      a_mag_q   <= a_mag_d;
      b_mag_q   <= b_mag_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      result_q  <= result_d;
    end
  end

  assign bus.Busy   = (state_q == S_CALC) || (state_q == S_FIXUP);
  assign bus.Done   = (state_q == S_DONE);
  assign bus.Result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed RV32M vectors, expected results queued at
// acceptance and checked by an independent monitor on each Done pulse.
module tb_muldiv_unit;

  logic Clk = 1'b0;
  logic Rst_n = 1'b0;
  always #5 Clk = ~Clk;

  muldiv_unit_if #(.XLEN(32)) bus ();

  muldiv_unit #(.XLEN(32), .CNT_W(6)) dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .bus   (bus.slave)
  );

  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_q[$];
  string       name_q[$];
  logic        done_prev = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Monitor: one pop per Done pulse (a Done frozen by En=0 is the same pulse)
  always @(negedge Clk) begin
    string       nm;
    logic [31:0] e;
    if (bus.Done === 1'b1 && !done_prev) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got Done with result %h want no Done", bus.Result);
      end else begin
        nm = name_q.pop_front();
        e  = exp_q.pop_front();
        $display("txn %s result=%h expected=%h", nm, bus.Result, e);
        check(nm, bus.Result, e);
      end
    end
    done_prev <= (bus.Done === 1'b1);
  end

  // Called right after the accepting edge. mode: 0 plain, 1 Start re-pulse at cycle 10,
  // 2 En low for 5 cycles from cycle 10, 3 reset at cycle 20.
  task automatic wait_done(input string nm, input int exp_edges, input int mode);
    int edges;
    int busy_cnt;
    edges    = 1;
    busy_cnt = 0;
    @(negedge Clk);
    bus.Start = 1'b0;
    bus.DataA = 32'hDEAD_BEEF;
    bus.DataB = 32'h0000_0003;
    bus.Op    = 3'd3;
    while (bus.Done !== 1'b1 && edges < 200) begin
      if (bus.Busy === 1'b1) busy_cnt++;
      if (mode == 1 && edges == 10) begin
        bus.Start = 1'b1;
        bus.Op    = 3'd5;
        bus.DataA = 32'd9;
        bus.DataB = 32'd4;
      end else if (mode == 1 && edges == 11) begin
        bus.Start = 1'b0;
      end
      if (mode == 2) bus.En = !(edges >= 10 && edges < 15);
      if (mode == 3 && edges == 20) begin
        Rst_n  = 1'b0;
        bus.En = 1'b0;
        @(posedge Clk);
        @(negedge Clk);
        Rst_n  = 1'b1;
        bus.En = 1'b1;
        check({nm, "_rst_busy"}, {31'd0, bus.Busy}, 32'd0);
        check({nm, "_rst_done"}, {31'd0, bus.Done}, 32'd0);
        check({nm, "_rst_result"}, bus.Result, 32'd0);
        repeat (40) @(negedge Clk);
        return;
      end
      @(posedge Clk);
      edges++;
      @(negedge Clk);
    end
    check({nm, "_latency"}, edges, exp_edges);
    check({nm, "_busy_at_done"}, {31'd0, bus.Busy}, 32'd0);
    if (mode == 0) check({nm, "_busy_cycles"}, busy_cnt, 33);
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int exp_edges, input int mode,
                        input string nm);
    @(negedge Clk);
    bus.Start = 1'b1;
    bus.Op    = op;
    bus.DataA = a;
    bus.DataB = b;
    @(posedge Clk);
    if (mode != 3) begin
      exp_q.push_back(exp);
      name_q.push_back(nm);
    end
    wait_done(nm, exp_edges, mode);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.En    = 1'b0;
    bus.Start = 1'b0;
    bus.Op    = 3'd0;
    bus.DataA = 32'd0;
    bus.DataB = 32'd0;
    Rst_n     = 1'b0;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    check("reset_busy", {31'd0, bus.Busy}, 32'd0);
    check("reset_done", {31'd0, bus.Done}, 32'd0);
    check("reset_result", bus.Result, 32'd0);
    Rst_n  = 1'b1;
    bus.En = 1'b1;

    // Multiply
    run_op(3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 34, 0, "mul_7_m3");
    run_op(3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 34, 0, "mulh_min_sq");
    run_op(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34, 0, "mulhu_max_sq");
    run_op(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 34, 0, "mulhsu_m1_max");
    run_op(3'd3, 32'h00010000, 32'h00010000, 32'h00000001, 34, 0, "mulhu_2p32");
    run_op(3'd0, 32'h00010000, 32'h00010000, 32'h00000000, 34, 0, "mul_2p32_lo");

    // Divide
    run_op(3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34, 0, "div_m7_2");
    run_op(3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34, 0, "rem_m7_2");
    run_op(3'd5, 32'd100,      32'd7,        32'd14,       34, 0, "divu_100_7");
    run_op(3'd7, 32'd100,      32'd7,        32'd2,        34, 0, "remu_100_7");
    run_op(3'd4, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 34, 0, "div_7_m2");
    run_op(3'd6, 32'd7,        32'hFFFFFFFE, 32'd1,        34, 0, "rem_7_m2");

    // Divide by zero and signed overflow
    run_op(3'd4, 32'd5,        32'd0,        32'hFFFFFFFF, 34, 0, "div_5_0");
    run_op(3'd4, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF, 34, 0, "div_m5_0");
    run_op(3'd6, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 34, 0, "rem_m5_0");
    run_op(3'd7, 32'h00001234, 32'd0,        32'h00001234, 34, 0, "remu_1234_0");
    run_op(3'd5, 32'h00001234, 32'd0,        32'hFFFFFFFF, 34, 0, "divu_1234_0");
    run_op(3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 34, 0, "div_ovf");
    run_op(3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 34, 0, "rem_ovf");

    // Start re-pulsed mid-operation, then Start in the Done cycle
    run_op(3'd0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 34, 1, "mul_repulse");
    bus.Start = 1'b1;
    bus.Op    = 3'd5;
    bus.DataA = 32'd100;
    bus.DataB = 32'd7;
    @(posedge Clk);
    @(negedge Clk);
    check("start_in_done_ignored", {31'd0, bus.Busy}, 32'd0);
    @(posedge Clk);
    exp_q.push_back(32'd14);
    name_q.push_back("divu_after_done");
    wait_done("divu_after_done", 34, 0);

    // Reset mid-operation, then clock-enable stall
    run_op(3'd5, 32'd100, 32'd7, 32'd14, 34, 3, "divu_reset_abort");
    run_op(3'd6, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 39, 2, "rem_en_stall");

    repeat (5) @(negedge Clk);
    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
